// File: rtl/reg_file_sb.sv
// 32x32 register file with two read ports, one write port,
// same-cycle write bypass and a pending-write scoreboard.
module reg_file_sb #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rready_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rready_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic             any_pending
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wr_ok;
  logic pd_ok;
  logic byp_a;
  logic byp_b;
  logic zero_a;
  logic zero_b;

  assign wr_ok  = we && (waddr != '0);
  assign pd_ok  = pend_set && (pend_addr != '0);
  assign byp_a  = wr_ok && (waddr == raddr_a);
  assign byp_b  = wr_ok && (waddr == raddr_b);
  assign zero_a = (raddr_a == '0);
  assign zero_b = (raddr_b == '0);

  // A set on the same edge as a write wins: a new producer was issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr]    <= wdata;
        pending[waddr] <= 1'b0;
      end
      if (pd_ok) begin
        pending[pend_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (!reset) begin
      unique case (1'b1)
        zero_a:  rdata_a = '0;
        byp_a:   rdata_a = wdata;
        default: rdata_a = regs[raddr_a];
      endcase
      unique case (1'b1)
        zero_b:  rdata_b = '0;
        byp_b:   rdata_b = wdata;
        default: rdata_b = regs[raddr_b];
      endcase
    end
  end

  assign rready_a = reset || zero_a || byp_a
                    || !pending[raddr_a];
  assign rready_b = reset || zero_b || byp_b
                    || !pending[raddr_b];

  assign any_pending = !reset && (|pending);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb: table of cycles
// plus hand-written reset and scoreboard sequences.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  raddr_a, raddr_b, waddr, pend_addr;
  logic [31:0] rdata_a, rdata_b, wdata;
  logic        rready_a, rready_b;
  logic        we, pend_set, any_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(32), .AW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .raddr_a     (raddr_a),
    .rdata_a     (rdata_a),
    .rready_a    (rready_a),
    .raddr_b     (raddr_b),
    .rdata_b     (rdata_b),
    .rready_b    (rready_b),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .pend_set    (pend_set),
    .pend_addr   (pend_addr),
    .any_pending (any_pending)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic        ya;
    logic [31:0] eb;
    logic        yb;
    logic        ep;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    we        = v.we;
    waddr     = v.wa;
    wdata     = v.wd;
    pend_set  = v.ps;
    pend_addr = v.pa;
    raddr_a   = v.ra;
    raddr_b   = v.rb;
  endtask

  task automatic check(input vec_t v, input int idx);
    chk("rdata_a", idx, rdata_a, v.ea);
    chk("rready_a", idx, 32'(rready_a), 32'(v.ya));
    chk("rdata_b", idx, rdata_b, v.eb);
    chk("rready_b", idx, 32'(rready_b), 32'(v.yb));
    chk("any_pending", idx, 32'(any_pending), 32'(v.ep));
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check(v, idx);
  endtask

  initial begin
    vec_t v;
    // rst we wa wd ps pa ra rb | ea ya eb yb ep
    vecs.push_back('{0,1,5,32'hDEADBEEF,0,0,5,0,
                     32'hDEADBEEF,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,5,5,
                     32'hDEADBEEF,1,32'hDEADBEEF,1,0});
    vecs.push_back('{0,1,0,32'h12345678,0,0,0,0,
                     0,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,5,
                     0,1,32'hDEADBEEF,1,0});
    vecs.push_back('{0,1,7,32'h1,0,0,7,7,
                     32'h1,1,32'h1,1,0});
    vecs.push_back('{0,1,7,32'hCAFEF00D,0,0,7,7,
                     32'hCAFEF00D,1,32'hCAFEF00D,1,0});
    vecs.push_back('{0,0,0,0,0,0,7,7,
                     32'hCAFEF00D,1,32'hCAFEF00D,1,0});
    vecs.push_back('{0,0,0,0,1,9,9,9,
                     0,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,9,5,
                     0,0,32'hDEADBEEF,1,1});
    vecs.push_back('{0,1,9,32'hA5A5A5A5,0,0,9,9,
                     32'hA5A5A5A5,1,32'hA5A5A5A5,1,1});
    vecs.push_back('{0,0,0,0,0,0,9,9,
                     32'hA5A5A5A5,1,32'hA5A5A5A5,1,0});
    vecs.push_back('{0,0,0,0,1,3,3,3,
                     0,1,0,1,0});
    vecs.push_back('{0,1,3,32'h55,1,3,3,3,
                     32'h55,1,32'h55,1,1});
    vecs.push_back('{0,0,0,0,0,0,3,3,
                     32'h55,0,32'h55,0,1});
    vecs.push_back('{0,0,0,0,1,0,0,3,
                     0,1,32'h55,0,1});
    vecs.push_back('{0,0,0,0,0,0,0,3,
                     0,1,32'h55,0,1});
    vecs.push_back('{0,1,3,32'h66,1,6,3,6,
                     32'h66,1,0,1,1});
    vecs.push_back('{0,0,0,0,0,0,3,6,
                     32'h66,1,0,0,1});
    vecs.push_back('{0,1,4,32'h77,0,0,4,4,
                     32'h77,1,32'h77,1,1});
    vecs.push_back('{0,0,0,0,1,4,4,6,
                     32'h77,1,0,0,1});
    vecs.push_back('{0,0,0,0,0,0,4,6,
                     32'h77,0,0,0,1});
    vecs.push_back('{1,1,4,32'h99,0,0,4,6,
                     0,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,4,6,
                     0,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,3,7,
                     0,1,0,1,0});

    // Initial reset, outputs forced while held.
    v = '{1,1,5,32'hFFFFFFFF,1,5,5,9,
          0,1,0,1,0};
    step(v, -1);
    @(posedge clk);

    // Every address reads zero and ready after reset.
    for (int i = 0; i < 32; i++) begin
      v = '{0,0,0,0,0,0,5'(i),5'(31 - i),
            0,1,0,1,0};
      step(v, 100 + i);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Pending holds across idle cycles until written.
    v = '{0,0,0,0,1,10,10,10,0,1,0,1,0};
    step(v, 200);
    for (int i = 0; i < 3; i++) begin
      v = '{0,0,0,0,0,0,10,0,0,0,0,1,1};
      step(v, 201 + i);
    end
    v = '{0,1,11,32'h0BADF00D,0,0,10,11,
          0,0,32'h0BADF00D,1,1};
    step(v, 204);
    v = '{0,1,10,32'h13579BDF,0,0,10,11,
          32'h13579BDF,1,32'h0BADF00D,1,1};
    step(v, 205);
    v = '{0,0,0,0,0,0,10,11,
          32'h13579BDF,1,32'h0BADF00D,1,0};
    step(v, 206);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
